// File: rtl/store_drain_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_drain_unit_pkg: shared types for the retired-store drain path   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package store_drain_unit_pkg;

  typedef logic [1:0] msize_t;

  localparam msize_t MSIZE_B = 2'd0;
  localparam msize_t MSIZE_H = 2'd1;
  localparam msize_t MSIZE_W = 2'd2;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wd;
  } m_w_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [31:0] wd;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_REQ  = 2'd1,
    SB_WAIT = 2'd2
  } sb_state_t;

endpackage
`default_nettype wire

// File: rtl/store_lane_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_lane_gen: byte strobes and lane-replicated data for one store   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module store_lane_gen
  import store_drain_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  msize_t      size,
  input  logic [31:0] wd,
  output logic [3:0]  dwstrb,
  output logic [31:0] dwdata
);

  // Size 3 falls through to the word encoding.
  always_comb begin
    dwstrb = 4'b1111;
    dwdata = wd;
    case (size)
      MSIZE_B: begin
        dwstrb = 4'b0001 << addr_lo;
        dwdata = {4{wd[7:0]}};
      end
      MSIZE_H: begin
        dwstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        dwdata = {2{wd[15:0]}};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_drain_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_drain_unit: in-order committed-store buffer draining to D-cache |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module store_drain_unit
  import store_drain_unit_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int SB_PTR_W = $clog2(SB_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  m_w_t        mw_in,
  output logic        mw_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        dreq,
  output logic        dwr,
  output logic [1:0]  dsize,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwstrb,
  input  logic        daddr_ok,
  input  logic        ddata_ok,
  output logic        sb_empty
);

  localparam logic [SB_PTR_W:0] ONE_ENTRY = (SB_PTR_W+1)'(1);

  sb_entry_t entries_q [SB_DEPTH];
  sb_entry_t entries_d [SB_DEPTH];

  logic [SB_PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [SB_PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [SB_PTR_W:0]   count;
  logic [SB_PTR_W-1:0] wr_idx, rd_idx;
  sb_state_t           state_q, state_d;

  logic                full, empty, push, pop, more_left;
  logic [SB_DEPTH-1:0] hit;
  logic                unused_ld_lo;

  assign wr_idx = wr_ptr_q[SB_PTR_W-1:0];
  assign rd_idx = rd_ptr_q[SB_PTR_W-1:0];
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[SB_PTR_W] != rd_ptr_q[SB_PTR_W]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign count  = wr_ptr_q - rd_ptr_q;

  assign mw_ready = ~full;
  assign sb_empty = empty;
  assign push     = mw_in.wen && mw_ready;
  assign pop      = ((state_q == SB_REQ) && daddr_ok && ddata_ok) ||
                    ((state_q == SB_WAIT) && ddata_ok);
  // A same-cycle push keeps the drain busy, so back-to-back stores see no dreq bubble.
  assign more_left = (count > ONE_ENTRY) || push;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (pop) begin
      entries_d[rd_idx].valid = 1'b0;
      rd_ptr_d                = rd_ptr_q + ONE_ENTRY;
    end
    if (push) begin
      entries_d[wr_idx] = '{valid: 1'b1, addr: mw_in.addr, size: mw_in.size, wd: mw_in.wd};
      wr_ptr_d          = wr_ptr_q + ONE_ENTRY;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE: if (!empty || push) state_d = SB_REQ;
      SB_REQ: begin
        if (daddr_ok) begin
          if (ddata_ok) state_d = more_left ? SB_REQ : SB_IDLE;
          else          state_d = SB_WAIT;
        end
      end
      SB_WAIT: if (ddata_ok) state_d = more_left ? SB_REQ : SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= SB_IDLE;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
    end
  end

  assign dreq  = (state_q == SB_REQ);
  assign dwr   = 1'b1;
  assign daddr = entries_q[rd_idx].addr;
  assign dsize = (entries_q[rd_idx].size == 2'd3) ? MSIZE_W : entries_q[rd_idx].size;

  store_lane_gen u_lane_gen (
    .addr_lo (entries_q[rd_idx].addr[1:0]),
    .size    (entries_q[rd_idx].size),
    .wd      (entries_q[rd_idx].wd),
    .dwstrb  (dwstrb),
    .dwdata  (dwdata)
  );

  // The tail slot is still invalid during its enqueue cycle, so it never matches.
  for (genvar g = 0; g < SB_DEPTH; g++) begin : g_conflict
    assign hit[g] = entries_q[g].valid && (entries_q[g].addr[31:2] == ld_addr[31:2]);
  end

  assign ld_conflict  = ld_valid && (|hit);
  assign unused_ld_lo = ^ld_addr[1:0];

endmodule
`default_nettype wire

// File: tb/tb_store_drain_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_store_drain_unit: directed self-checking bench for store_drain_unit|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_store_drain_unit;
  import store_drain_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  m_w_t        mw_in;
  logic        mw_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        dreq, dwr;
  logic [1:0]  dsize;
  logic [31:0] daddr, dwdata;
  logic [3:0]  dwstrb;
  logic        daddr_ok, ddata_ok;
  logic        sb_empty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_drain_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mw_in       (mw_in),
    .mw_ready    (mw_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_conflict (ld_conflict),
    .dreq        (dreq),
    .dwr         (dwr),
    .dsize       (dsize),
    .daddr       (daddr),
    .dwdata      (dwdata),
    .dwstrb      (dwstrb),
    .daddr_ok    (daddr_ok),
    .ddata_ok    (ddata_ok),
    .sb_empty    (sb_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    mw_in = '{wen: 1'b1, addr: a, size: s, wd: d};
  endtask

  initial begin
    reset    = 1'b1;
    mw_in    = '0;
    ld_valid = 1'b1;
    ld_addr  = 32'h0;
    daddr_ok = 1'b0;
    ddata_ok = 1'b0;
    tick();
    tick();
    chk("rst_mw_ready",    32'(mw_ready),    32'd1);
    chk("rst_sb_empty",    32'(sb_empty),    32'd1);
    chk("rst_dreq",        32'(dreq),        32'd0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);
    reset    = 1'b0;
    ld_valid = 1'b0;
    tick();

    // single word store
    store(32'h1000_0004, MSIZE_W, 32'hDEAD_BEEF);
    #1 chk("t1_ready_pre", 32'(mw_ready), 32'd1);
    tick();
    mw_in = '0;
    #1;
    chk("t1_dreq",   32'(dreq),   32'd1);
    chk("t1_daddr",  daddr,       32'h1000_0004);
    chk("t1_dwstrb", 32'(dwstrb), 32'hF);
    chk("t1_dwdata", dwdata,      32'hDEAD_BEEF);
    chk("t1_dsize",  32'(dsize),  32'd2);
    chk("t1_dwr",    32'(dwr),    32'd1);
    chk("t1_empty",  32'(sb_empty), 32'd0);
    ddata_ok = 1'b1;
    tick();
    ddata_ok = 1'b0;
    #1;
    chk("t1_stray_data_dreq",  32'(dreq),     32'd1);
    chk("t1_stray_data_empty", 32'(sb_empty), 32'd0);
    daddr_ok = 1'b1;
    tick();
    daddr_ok = 1'b0;
    ddata_ok = 1'b1;
    #1;
    chk("t1_wait_dreq",  32'(dreq),     32'd0);
    chk("t1_wait_empty", 32'(sb_empty), 32'd0);
    tick();
    ddata_ok = 1'b0;
    #1;
    chk("t1_drained_empty", 32'(sb_empty), 32'd1);
    chk("t1_idle_dreq",     32'(dreq),     32'd0);

    // byte at offset 3, then half pushed while the byte pops
    store(32'h1000_0003, MSIZE_B, 32'h1234_565A);
    tick();
    mw_in = '0;
    #1;
    chk("t2_byte_strb",  32'(dwstrb), 32'h8);
    chk("t2_byte_data",  dwdata,      32'h5A5A_5A5A);
    chk("t2_byte_dsize", 32'(dsize),  32'd0);
    daddr_ok = 1'b1;
    ddata_ok = 1'b1;
    store(32'h1000_0002, MSIZE_H, 32'h1111_BEEF);
    tick();
    mw_in = '0;
    #1;
    chk("t2_half_dreq",  32'(dreq),     32'd1);
    chk("t2_half_addr",  daddr,         32'h1000_0002);
    chk("t2_half_strb",  32'(dwstrb),   32'hC);
    chk("t2_half_data",  dwdata,        32'hBEEF_BEEF);
    chk("t2_half_empty", 32'(sb_empty), 32'd0);
    tick();
    daddr_ok = 1'b0;
    ddata_ok = 1'b0;
    #1;
    chk("t2_empty", 32'(sb_empty), 32'd1);
    chk("t2_dreq",  32'(dreq),     32'd0);
    store(32'h1000_0001, MSIZE_B, 32'h0000_00C3);
    tick();
    mw_in = '0;
    #1;
    chk("t2_byte1_strb", 32'(dwstrb), 32'h2);
    chk("t2_byte1_data", dwdata,      32'hC3C3_C3C3);
    daddr_ok = 1'b1;
    ddata_ok = 1'b1;
    tick();
    daddr_ok = 1'b0;
    ddata_ok = 1'b0;

    // five back-to-back stores with the cache stalling
    for (int i = 0; i < 4; i++) begin
      store(32'h3000_0000 + 32'(4 * i), MSIZE_W, 32'hA000_0000 + 32'(i));
      #1 chk("t3_ready_fill", 32'(mw_ready), 32'd1);
      tick();
    end
    store(32'h3000_0010, MSIZE_W, 32'hA000_0004);
    #1;
    chk("t3_full_ready", 32'(mw_ready), 32'd0);
    chk("t3_full_head",  daddr,         32'h3000_0000);
    chk("t3_full_dreq",  32'(dreq),     32'd1);
    tick();
    chk("t3_held_ready", 32'(mw_ready), 32'd0);
    chk("t3_held_head",  daddr,         32'h3000_0000);
    daddr_ok = 1'b1;
    tick();
    daddr_ok = 1'b0;
    ddata_ok = 1'b1;
    #1;
    chk("t3_wait_ready", 32'(mw_ready), 32'd0);
    chk("t3_wait_dreq",  32'(dreq),     32'd0);
    tick();
    ddata_ok = 1'b0;
    #1;
    chk("t3_pop_ready", 32'(mw_ready), 32'd1);
    chk("t3_pop_dreq",  32'(dreq),     32'd1);
    chk("t3_pop_head",  daddr,         32'h3000_0004);
    tick();
    mw_in = '0;
    #1;
    chk("t3_refull_ready", 32'(mw_ready), 32'd0);
    daddr_ok = 1'b1;
    ddata_ok = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("t3_order_addr", daddr,     32'h3000_0000 + 32'(4 * i));
      chk("t3_order_data", dwdata,    32'hA000_0000 + 32'(i));
      chk("t3_no_bubble",  32'(dreq), 32'd1);
      tick();
      #1;
    end
    daddr_ok = 1'b0;
    ddata_ok = 1'b0;
    chk("t3_drained_empty", 32'(sb_empty), 32'd1);
    chk("t3_drained_dreq",  32'(dreq),     32'd0);

    // load conflict detection
    store(32'h2000_0008, MSIZE_W, 32'h0000_0055);
    ld_valid = 1'b1;
    ld_addr  = 32'h2000_000B;
    #1 chk("t5_enq_excluded", 32'(ld_conflict), 32'd0);
    tick();
    mw_in = '0;
    #1 chk("t5_conflict", 32'(ld_conflict), 32'd1);
    ld_addr = 32'h2000_000C;
    #1 chk("t5_next_word", 32'(ld_conflict), 32'd0);
    ld_addr = 32'h3000_0004;
    #1 chk("t5_stale_entry", 32'(ld_conflict), 32'd0);
    ld_addr  = 32'h2000_0008;
    ld_valid = 1'b0;
    #1 chk("t5_no_valid", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b1;
    #1 chk("t5_conflict_again", 32'(ld_conflict), 32'd1);
    daddr_ok = 1'b1;
    ddata_ok = 1'b1;
    tick();
    daddr_ok = 1'b0;
    ddata_ok = 1'b0;
    #1 chk("t5_after_drain", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b0;

    // reset while waiting with three entries buffered
    for (int i = 0; i < 3; i++) begin
      store(32'h4000_0000 + 32'(4 * i), MSIZE_W, 32'(i));
      tick();
    end
    mw_in    = '0;
    daddr_ok = 1'b1;
    tick();
    daddr_ok = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h4000_0004;
    #1;
    chk("t6_wait_dreq",     32'(dreq),        32'd0);
    chk("t6_pre_empty",     32'(sb_empty),    32'd0);
    chk("t6_pre_conflict",  32'(ld_conflict), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_dreq",     32'(dreq),        32'd0);
    chk("t6_rst_empty",    32'(sb_empty),    32'd1);
    chk("t6_rst_ready",    32'(mw_ready),    32'd1);
    chk("t6_rst_conflict", 32'(ld_conflict), 32'd0);
    tick();
    reset    = 1'b0;
    ddata_ok = 1'b1;
    tick();
    ddata_ok = 1'b0;
    #1;
    chk("t6_late_empty", 32'(sb_empty), 32'd1);
    chk("t6_late_dreq",  32'(dreq),     32'd0);
    chk("t6_late_ready", 32'(mw_ready), 32'd1);
    ld_valid = 1'b0;
    store(32'h5000_0010, MSIZE_H, 32'h0000_CAFE);
    tick();
    mw_in = '0;
    #1;
    chk("t6_restart_dreq", 32'(dreq),   32'd1);
    chk("t6_restart_addr", daddr,       32'h5000_0010);
    chk("t6_restart_strb", 32'(dwstrb), 32'h3);
    chk("t6_restart_data", dwdata,      32'hCAFE_CAFE);
    daddr_ok = 1'b1;
    ddata_ok = 1'b1;
    tick();
    daddr_ok = 1'b0;
    ddata_ok = 1'b0;
    #1 chk("t6_final_empty", 32'(sb_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
